dma_channel_arbiter: RTL and testbench

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

---
 rtl/dma_channel_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: merges hardware/software requests, raises HRQ to the
// CPU, and on HLDA grants one channel (fixed or rotating priority) until the
// transfer completes or the hold is withdrawn.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   DREQ[NUM_CH]        hardware requests (polarity from dreqSenseLow)
//   softwareReq[NUM_CH] software requests, never masked
//   maskReg[NUM_CH]     1 = ignore that channel's DREQ
//   rotatingPriority    0 = fixed (ch0 highest), 1 = rotating
//   dreqSenseLow        1 = DREQ active-low
//   dackSenseHigh       1 = DACK active-high
//   controllerDisable   1 = do not raise a new HRQ
//   HLDA                hold acknowledge
//   transferDone        end-of-service pulse
//   HRQ                 hold request (registered)
//   DACK[NUM_CH]        one-hot acknowledge, polarity from dackSenseHigh
//   grantValid          channel in service
//   grantChannel[CH_W]  serviced channel index, 0 when idle
module dma_channel_arbiter #(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] softwareReq,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              rotatingPriority,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              controllerDisable,
    input  logic              HLDA,
    input  logic              transferDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantChannel
);

    typedef enum logic [1:0] {IDLE, REQUEST, GRANT, RELEASE} state_t;

    state_t             r_state;
    logic               r_hrq;
    logic [NUM_CH-1:0]  r_dack;
    logic               r_grant_valid;
    logic [CH_W-1:0]    r_grant_ch;
    logic [CH_W-1:0]    r_last_ch;

    state_t             w_state_nxt;
    logic               w_hrq_nxt;
    logic [NUM_CH-1:0]  w_dack_nxt;
    logic               w_grant_valid_nxt;
    logic [CH_W-1:0]    w_grant_ch_nxt;
    logic [CH_W-1:0]    w_last_ch_nxt;

    logic [NUM_CH-1:0]  w_req;
    logic               w_win_found;
    logic [CH_W-1:0]    w_win_ch;

    // Effective per-channel request after polarity and mask
    always_comb begin
        w_req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | softwareReq;
    end

    // Winner search: start at channel 0 (fixed) or one past lastCh (rotating)
    always_comb begin
        int idx;
        w_win_found = 1'b0;
        w_win_ch    = '0;
        idx         = 0;
        for (int off = 0; off < int'(NUM_CH); off++) begin
            if (rotatingPriority) begin
                idx = (int'(r_last_ch) + 1 + off) % int'(NUM_CH);
            end else begin
                idx = off;
            end
            if (!w_win_found && w_req[idx]) begin
                w_win_found = 1'b1;
                w_win_ch    = CH_W'(idx);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_hrq_nxt         = r_hrq;
        w_dack_nxt        = r_dack;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_ch_nxt    = r_grant_ch;
        w_last_ch_nxt     = r_last_ch;

        case (r_state)
            IDLE: begin
                w_hrq_nxt         = 1'b0;
                w_dack_nxt        = '0;
                w_grant_valid_nxt = 1'b0;
                w_grant_ch_nxt    = '0;
                if ((|w_req) && !controllerDisable) begin
                    w_state_nxt = REQUEST;
                    w_hrq_nxt   = 1'b1;
                end
            end
            REQUEST: begin
                if (!(|w_req) || controllerDisable) begin
                    w_state_nxt = IDLE;
                    w_hrq_nxt   = 1'b0;
                end else if (HLDA && w_win_found) begin
                    w_state_nxt       = GRANT;
                    w_dack_nxt        = NUM_CH'(1) << w_win_ch;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_ch_nxt    = w_win_ch;
                end
            end
            GRANT: begin
                // Completion wins over a simultaneous HLDA drop; only it moves lastCh
                if (transferDone || !HLDA) begin
                    if (transferDone) begin
                        w_last_ch_nxt = r_grant_ch;
                    end
                    w_state_nxt       = RELEASE;
                    w_hrq_nxt         = 1'b0;
                    w_dack_nxt        = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_grant_ch_nxt    = '0;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_hrq         <= 1'b0;
            r_dack        <= '0;
            r_grant_valid <= 1'b0;
            r_grant_ch    <= '0;
            r_last_ch     <= CH_W'(NUM_CH - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_hrq         <= w_hrq_nxt;
            r_dack        <= w_dack_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_ch    <= w_grant_ch_nxt;
            r_last_ch     <= w_last_ch_nxt;
        end
    end

    assign HRQ          = r_hrq;
    assign DACK         = r_dack ^ {NUM_CH{~dackSenseHigh}};
    assign grantValid   = r_grant_valid;
    assign grantChannel = r_grant_ch;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: transaction-level model for a
// 4-channel instance under random and directed stimulus, plus a directed
// rotation check on an 8-channel instance.
module tb_dma_channel_arbiter;

    localparam int unsigned N = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [N-1:0] DREQ = '0;
    logic [N-1:0] softwareReq = '0;
    logic [N-1:0] maskReg = '0;
    logic         rotatingPriority = 1'b0;
    logic         dreqSenseLow = 1'b0;
    logic         dackSenseHigh = 1'b1;
    logic         controllerDisable = 1'b0;
    logic         HLDA = 1'b0;
    logic         transferDone = 1'b0;
    logic         HRQ;
    logic [N-1:0] DACK;
    logic         grantValid;
    logic [1:0]   grantChannel;

    // 8-channel instance, directed use only
    logic         RESET8 = 1'b1;
    logic [7:0]   DREQ8 = '0;
    logic [7:0]   zero8 = '0;
    logic         HLDA8 = 1'b0;
    logic         done8 = 1'b0;
    logic         one = 1'b1;
    logic         zero = 1'b0;
    logic         HRQ8;
    logic [7:0]   DACK8;
    logic         gv8;
    logic [2:0]   gch8;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    // Model: hold requested, channel in service, one-cycle cool-down after service
    bit m_hrq = 0;
    bit m_serv = 0;
    bit m_cool = 0;
    int m_ch = 0;
    int m_last = N - 1;

    always #5 CLK = ~CLK;

    dma_channel_arbiter #(.NUM_CH(N)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .softwareReq(softwareReq),
        .maskReg(maskReg), .rotatingPriority(rotatingPriority),
        .dreqSenseLow(dreqSenseLow), .dackSenseHigh(dackSenseHigh),
        .controllerDisable(controllerDisable), .HLDA(HLDA),
        .transferDone(transferDone), .HRQ(HRQ), .DACK(DACK),
        .grantValid(grantValid), .grantChannel(grantChannel)
    );

    dma_channel_arbiter #(.NUM_CH(8)) dut8 (
        .CLK(CLK), .RESET(RESET8), .DREQ(DREQ8), .softwareReq(zero8),
        .maskReg(zero8), .rotatingPriority(one), .dreqSenseLow(zero),
        .dackSenseHigh(one), .controllerDisable(zero), .HLDA(HLDA8),
        .transferDone(done8), .HRQ(HRQ8), .DACK(DACK8),
        .grantValid(gv8), .grantChannel(gch8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] eff_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            logic hw;
            hw = dreqSenseLow ? !DREQ[i] : DREQ[i];
            r[i] = softwareReq[i] || (hw && !maskReg[i]);
        end
        return r;
    endfunction

    // Winner = requester at smallest distance from the top-priority slot
    function automatic int pick(input logic [N-1:0] r);
        int best = -1;
        int bestd = 1000;
        for (int i = 0; i < N; i++) begin
            int d;
            d = rotatingPriority ? (i - m_last - 1 + 2 * N) % N : i;
            if (r[i] && d < bestd) begin
                bestd = d;
                best = i;
            end
        end
        return best;
    endfunction

    always @(posedge CLK) begin
        logic [N-1:0] r;
        r = eff_req();
        if (RESET) begin
            m_hrq = 0; m_serv = 0; m_cool = 0; m_ch = 0; m_last = N - 1;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_serv) begin
            if (transferDone || !HLDA) begin
                if (transferDone) m_last = m_ch;
                m_serv = 0; m_hrq = 0; m_cool = 1; m_ch = 0;
            end
        end else if (m_hrq) begin
            if (r == 0 || controllerDisable) m_hrq = 0;
            else if (HLDA) begin
                m_serv = 1;
                m_ch = pick(r);
            end
        end else if (r != 0 && !controllerDisable) begin
            m_hrq = 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [N-1:0] exp_dack;
            exp_dack = (m_serv ? (N'(1) << m_ch) : N'(0)) ^ {N{~dackSenseHigh}};
            chk("model_HRQ", 32'(HRQ), 32'(m_hrq));
            chk("model_DACK", 32'(DACK), 32'(exp_dack));
            chk("model_grantValid", 32'(grantValid), 32'(m_serv));
            chk("model_grantChannel", 32'(grantChannel), m_serv ? 32'(m_ch) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        HLDA = 1'b0;
        transferDone = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_hrq();
        int k = 0;
        while (HRQ !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("HRQ_rise", 32'(HRQ), 32'd1);
    endtask

    task automatic serve(input int exp_ch);
        wait_hrq();
        HLDA = 1'b1;
        tick();
        chk("grant_valid", 32'(grantValid), 32'd1);
        chk("grant_channel", 32'(grantChannel), 32'(exp_ch));
        chk("grant_DACK", 32'(DACK), 32'(N'(1) << exp_ch));
        transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        HLDA = 1'b0;
        chk("done_HRQ", 32'(HRQ), 32'd0);
        chk("done_DACK", 32'(DACK), 32'd0);
    endtask

    task automatic serve8(input int exp_ch);
        int k = 0;
        while (HRQ8 !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("HRQ8_rise", 32'(HRQ8), 32'd1);
        HLDA8 = 1'b1;
        tick();
        chk("grant8_channel", 32'(gch8), 32'(exp_ch));
        chk("grant8_DACK", 32'(DACK8), 32'(8'd1 << exp_ch));
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        HLDA8 = 1'b0;
        chk("done8_valid", 32'(gv8), 32'd0);
    endtask

    initial begin
        // Reset values in both DACK polarities
        tick();
        chk_en = 1;
        chk("rst_HRQ", 32'(HRQ), 32'd0);
        chk("rst_DACK_high", 32'(DACK), 32'h0);
        chk("rst_grantValid", 32'(grantValid), 32'd0);
        dackSenseHigh = 1'b0;
        #1;
        chk("rst_DACK_low", 32'(DACK), 32'hF);
        dackSenseHigh = 1'b1;
        RESET = 1'b0;

        // Basic latency: HRQ after 1, DACK after 1, release after 1, new HRQ at +3
        DREQ = 4'b0001;
        tick();
        chk("lat_HRQ", 32'(HRQ), 32'd1);
        HLDA = 1'b1;
        tick();
        chk("lat_DACK", 32'(DACK), 32'h1);
        chk("lat_ch", 32'(grantChannel), 32'd0);
        transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        HLDA = 1'b0;
        chk("lat_rel_DACK", 32'(DACK), 32'h0);
        chk("lat_rel_HRQ", 32'(HRQ), 32'd0);
        tick();
        chk("lat_k2_HRQ", 32'(HRQ), 32'd0);
        tick();
        chk("lat_k3_HRQ", 32'(HRQ), 32'd1);
        DREQ = '0;
        do_reset();

        // Fixed priority
        DREQ = 4'b1010;
        serve(1);
        DREQ = 4'b1000;
        serve(3);
        DREQ = '0;
        do_reset();

        // Rotating priority walk
        rotatingPriority = 1'b1;
        DREQ = 4'b1111;
        serve(0); serve(1); serve(2); serve(3); serve(0);
        DREQ = '0;
        rotatingPriority = 1'b0;
        do_reset();

        // Masked DREQ stays silent, software request is not maskable
        maskReg = 4'b0001;
        DREQ = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mask_HRQ", 32'(HRQ), 32'd0);
        end
        softwareReq = 4'b0001;
        serve(0);
        softwareReq = '0;
        maskReg = '0;
        DREQ = '0;
        do_reset();

        // Reset during grant of ch2 restores lastCh
        rotatingPriority = 1'b1;
        DREQ = 4'b1111;
        serve(0);
        serve(1);
        wait_hrq();
        HLDA = 1'b1;
        tick();
        chk("pre_rst_ch", 32'(grantChannel), 32'd2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        HLDA = 1'b0;
        chk("grst_HRQ", 32'(HRQ), 32'd0);
        chk("grst_DACK", 32'(DACK), 32'h0);
        chk("grst_valid", 32'(grantValid), 32'd0);
        chk("grst_ch", 32'(grantChannel), 32'd0);
        serve(0);
        DREQ = '0;
        rotatingPriority = 1'b0;
        do_reset();

        // 8-channel rotation order 0..7,0
        RESET8 = 1'b0;
        DREQ8 = 8'hFF;
        for (int i = 0; i < 9; i++) serve8(i % 8);
        DREQ8 = '0;

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                rotatingPriority = 1'($urandom);
                dreqSenseLow = 1'($urandom);
                dackSenseHigh = 1'($urandom);
            end
            if ($urandom % 4 == 0) DREQ = N'($urandom);
            if ($urandom % 32 == 0) maskReg = N'($urandom);
            softwareReq = ($urandom % 8 == 0) ? N'($urandom) : N'(0);
            controllerDisable = ($urandom % 16 == 0);
            HLDA = HRQ ? ($urandom % 10 != 0) : ($urandom % 4 == 0);
            transferDone = grantValid ? ($urandom % 4 == 0) : ($urandom % 16 == 0);
            RESET = ($urandom % 100 == 0);
            tick();
        end
        RESET = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
